// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - decode-interface bundle type produced by fetch_unit
package fetch_unit_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imp;
  } D_type;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: one outstanding bus request,
// 1-entry skid buffer for decode stalls, single-delay-slot redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcf1,
  input  logic        ifj,
  input  logic [31:0] pc_decode,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output D_type       D,
  output logic        d_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] wait_pc_q, wait_pc_d;
  logic [31:0] redir_target_q, redir_target_d;
  logic        redir_pending_q, redir_pending_d;
  logic        drop_q, drop_d;
  logic        req_kill_q, req_kill_d;
  logic        buf_valid_q, buf_valid_d;
  D_type       buf_q, buf_d;
  D_type       d_q, d_d;
  logic        d_valid_q, d_valid_d;

  logic        redir, accept, resp, resp_live, direct, buf_kill;
  logic [31:0] slot_pc, next_pc;

  assign ireq_valid = resetn && (state_q == S_REQ);
  assign ireq_addr  = {req_pc_q[31:2], 2'b00};
  assign D          = d_q;
  assign d_valid    = d_valid_q;

  always_comb begin
    redir     = ifj && d_valid_q && !pcf1;
    slot_pc   = d_q.pc + 32'd4;
    accept    = (state_q == S_REQ) && iresp_addr_ok;
    resp      = (state_q == S_WAIT) && iresp_data_ok;
    resp_live = resp && !drop_q && !(redir && wait_pc_q != slot_pc);
    buf_kill  = redir && buf_valid_q && (buf_q.pc != slot_pc);
    direct    = resp_live && !pcf1 && !buf_valid_q;
    next_pc   = redir_pending_q ? redir_target_q : req_pc_q + 32'd4;

    state_d         = state_q;
    req_pc_d        = req_pc_q;
    wait_pc_d       = wait_pc_q;
    redir_target_d  = redir_target_q;
    redir_pending_d = redir_pending_q;
    drop_d          = drop_q;
    req_kill_d      = req_kill_q;
    buf_valid_d     = buf_valid_q;
    buf_d           = buf_q;
    d_d             = d_q;
    d_valid_d       = d_valid_q;

    if (!pcf1) begin
      if (buf_valid_q && !buf_kill) begin
        d_d       = buf_q;
        d_valid_d = 1'b1;
      end else if (direct) begin
        d_d       = {wait_pc_q, iresp_data};
        d_valid_d = 1'b1;
      end else begin
        d_d       = '0;
        d_valid_d = 1'b0;
      end
      buf_valid_d = 1'b0;
    end
    if (resp_live && !direct) begin
      buf_valid_d = 1'b1;
      buf_d       = {wait_pc_q, iresp_data};
    end

    if (resp) begin
      drop_d = 1'b0;
    end else if ((state_q == S_WAIT) && redir && (wait_pc_q != slot_pc)) begin
      drop_d = 1'b1;
    end

    if (accept) begin
      wait_pc_d       = req_pc_q;
      req_pc_d        = next_pc;
      redir_pending_d = 1'b0;
      req_kill_d      = 1'b0;
      drop_d          = req_kill_q || (redir && (req_pc_q != slot_pc));
    end

    // A wrong-path request still on the bus keeps its address; it is only
    // marked for dropping and the target follows it through redir_pending.
    if (redir) begin
      redir_target_d = pc_decode;
      if (accept) begin
        req_pc_d        = pc_decode;
        redir_pending_d = 1'b0;
      end else if ((state_q == S_REQ) && (req_pc_q != slot_pc)) begin
        req_kill_d      = 1'b1;
        redir_pending_d = 1'b1;
      end else if (req_pc_q == slot_pc) begin
        redir_pending_d = 1'b1;
      end else begin
        req_pc_d        = pc_decode;
        redir_pending_d = 1'b0;
      end
    end

    case (state_q)
      S_REQ:   if (accept) state_d = S_WAIT;
      S_WAIT:  if (resp) state_d = buf_valid_d ? S_HOLD : S_REQ;
      S_HOLD:  if (!buf_valid_d) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_REQ;
      req_pc_q        <= RESET_PC;
      wait_pc_q       <= '0;
      redir_target_q  <= '0;
      redir_pending_q <= 1'b0;
      drop_q          <= 1'b0;
      req_kill_q      <= 1'b0;
      buf_valid_q     <= 1'b0;
      buf_q           <= '0;
      d_q             <= '0;
      d_valid_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_pc_q        <= req_pc_d;
      wait_pc_q       <= wait_pc_d;
      redir_target_q  <= redir_target_d;
      redir_pending_q <= redir_pending_d;
      drop_q          <= drop_d;
      req_kill_q      <= req_kill_d;
      buf_valid_q     <= buf_valid_d;
      buf_q           <= buf_d;
      d_q             <= d_d;
      d_valid_q       <= d_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a scripted instruction bus
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pcf1 = 1'b0;
  logic        ifj = 1'b0;
  logic [31:0] pc_decode = '0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  D_type       D;
  logic        d_valid;

  fetch_unit #(.RESET_PC(RST)) dut (
    .clk(clk), .resetn(resetn), .pcf1(pcf1), .ifj(ifj), .pc_decode(pc_decode),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .D(D), .d_valid(d_valid)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_d_q[$];
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          data_due = 0;
  int          data_lat = 1;
  int          cyc = 0;
  logic        prev_pcf1 = 1'b0;
  logic [31:0] cur_pc = '0;
  logic        cur_v = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e;
    check("addr_align", {30'd0, ireq_addr[1:0]}, 32'd0);
    if (prev_pcf1) begin
      check("hold_pc", D.pc, cur_pc);
      check("hold_valid", 32'(d_valid), 32'(cur_v));
    end else if (d_valid) begin
      if (exp_d_q.size() == 0) begin
        check("d_unexpected", 32'(d_valid), 32'd0);
      end else begin
        e = exp_d_q.pop_front();
        check("d_pc", D.pc, e);
        check("d_imp", D.imp, mem(e));
        cur_pc = e;
        cur_v  = 1'b1;
      end
    end else begin
      check("bubble_pc", D.pc, 32'd0);
      check("bubble_imp", D.imp, 32'd0);
      cur_pc = '0;
      cur_v  = 1'b0;
    end
  endtask

  task automatic drive_bus();
    logic [31:0] e;
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    if (pend && cyc >= data_due) begin
      iresp_data_ok = 1'b1;
      iresp_data    = mem(pend_addr);
      pend          = 1'b0;
    end else if (!pend && ireq_valid && exp_addr_q.size() > 0) begin
      e = exp_addr_q.pop_front();
      check("req_addr", ireq_addr, e);
      iresp_addr_ok = 1'b1;
      pend_addr     = ireq_addr;
      pend          = 1'b1;
      data_due      = cyc + data_lat;
    end
  endtask

  task automatic cycle();
    check_outputs();
    drive_bus();
    prev_pcf1 = pcf1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_for_d(input logic [31:0] pc);
    int n = 0;
    while (!(d_valid && D.pc == pc && !prev_pcf1) && n < 60) begin
      cycle();
      n++;
    end
    if (n >= 60) check("wait_d_timeout", D.pc, pc);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_addr_q.size() > 0 || exp_d_q.size() > 0 || pend) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(exp_d_q.size() + exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(ireq_valid), 32'd0);
    check("rst_addr", ireq_addr, RST);
    check("rst_dvalid", 32'(d_valid), 32'd0);
    check("rst_dpc", D.pc, 32'd0);
    resetn = 1'b1;
    #1;
    check("first_valid", 32'(ireq_valid), 32'd1);

    // straight line, then a stall (with an ignored redirect) while 08 returns
    foreach (exp_addr_q[i]) ;
    exp_addr_q.push_back(RST);
    exp_addr_q.push_back(RST + 32'h4);
    exp_addr_q.push_back(RST + 32'h8);
    exp_d_q.push_back(RST);
    exp_d_q.push_back(RST + 32'h4);
    exp_d_q.push_back(RST + 32'h8);
    wait_for_d(RST + 32'h4);
    pcf1      = 1'b1;
    ifj       = 1'b1;
    pc_decode = RST + 32'h300;
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) check("hold_no_req", 32'(ireq_valid), 32'd0);
      cycle();
    end
    pcf1 = 1'b0;
    ifj  = 1'b0;
    cycle();
    check("stall_release_pc", D.pc, RST + 32'h8);
    check("stall_release_valid", 32'(d_valid), 32'd1);

    // taken branch at 10 with delay slot 14 waiting on a slow response
    exp_addr_q.push_back(RST + 32'hC);
    exp_addr_q.push_back(RST + 32'h10);
    exp_addr_q.push_back(RST + 32'h14);
    exp_addr_q.push_back(RST + 32'h100);
    exp_d_q.push_back(RST + 32'hC);
    exp_d_q.push_back(RST + 32'h10);
    exp_d_q.push_back(RST + 32'h14);
    exp_d_q.push_back(RST + 32'h100);
    wait_for_d(RST + 32'h10);
    data_lat = 3;
    pcf1     = 1'b1;
    cycle();
    cycle();
    pcf1      = 1'b0;
    ifj       = 1'b1;
    pc_decode = RST + 32'h100;
    cycle();
    ifj      = 1'b0;
    data_lat = 1;

    // branch at 100 (slot 104 accepted same cycle), then a branch in the slot
    // that kills the in-flight target fetch of 200
    exp_addr_q.push_back(RST + 32'h104);
    exp_addr_q.push_back(RST + 32'h200);
    exp_addr_q.push_back(RST + 32'h400);
    exp_d_q.push_back(RST + 32'h104);
    exp_d_q.push_back(RST + 32'h400);
    wait_for_d(RST + 32'h100);
    ifj       = 1'b1;
    pc_decode = RST + 32'h200;
    cycle();
    ifj = 1'b0;
    wait_for_d(RST + 32'h104);
    ifj       = 1'b1;
    pc_decode = RST + 32'h400;
    cycle();
    ifj = 1'b0;
    wait_for_d(RST + 32'h400);

    // buffer an entry under stall, then reset asynchronously mid-operation
    pcf1 = 1'b1;
    exp_addr_q.push_back(RST + 32'h404);
    for (int i = 0; i < 3; i++) cycle();
    check("hold_state_req", 32'(ireq_valid), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_valid", 32'(ireq_valid), 32'd0);
    check("midrst_dvalid", 32'(d_valid), 32'd0);
    check("midrst_dpc", D.pc, 32'd0);
    check("midrst_addr", ireq_addr, RST);
    exp_addr_q.delete();
    exp_d_q.delete();
    pend          = 1'b0;
    cur_pc        = '0;
    cur_v         = 1'b0;
    prev_pcf1     = 1'b0;
    pcf1          = 1'b0;
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_addr_q.push_back(RST);
    exp_addr_q.push_back(RST + 32'h4);
    exp_d_q.push_back(RST);
    exp_d_q.push_back(RST + 32'h4);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
